// File: rtl/mmio_rr_arbiter.sv
// Round-robin arbiter sharing one MMIO slot between N_REQ requesters.
// Each grant issues one single-beat access as a one-cycle chip-select strobe and acks it one cycle later.
module mmio_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_wr,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         resp_data,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      slot_cs,
  output logic                      slot_rd,
  output logic                      slot_wr,
  output logic [ADDR_W-1:0]         slot_addr,
  output logic [DATA_W-1:0]         slot_wdata,
  input  logic [DATA_W-1:0]         slot_rdata,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      grant_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   resp_q;

  logic                found;
  logic [IDW-1:0]      winner;
  logic [IDW-1:0]      ptr_next;

  // Search upward from the pointer with wrap; the first set request wins.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign ptr_next = (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Requester inputs are captured only on the IDLE grant; later changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      if (state_q == S_IDLE && found) begin
        ptr_q   <= ptr_next;
        grant_q <= winner;
        wr_q    <= req_wr[winner];
        addr_q  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[int'(winner)*DATA_W +: DATA_W];
      end
      if (state_q == S_ISSUE && !wr_q) begin
        resp_q <= slot_rdata;
      end
    end
  end

  always_comb begin
    ack     = '0;
    slot_cs = (state_q == S_ISSUE);
    slot_rd = (state_q == S_ISSUE) && !wr_q;
    slot_wr = (state_q == S_ISSUE) && wr_q;
    busy    = (state_q != S_IDLE);
    if (state_q == S_RESP) begin
      ack[grant_q] = 1'b1;
    end
  end

  assign resp_data  = resp_q;
  assign grant_id   = grant_q;
  assign slot_addr  = addr_q;
  assign slot_wdata = wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mmio_rr_arbiter.sv
// Directed bench for mmio_rr_arbiter: single read/write, contention order, wrap/skip, withdraw, reset mid-op.
module tb_mmio_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   resp_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic            slot_cs;
  logic            slot_rd;
  logic            slot_wr;
  logic [AW-1:0]   slot_addr;
  logic [DW-1:0]   slot_wdata;
  logic [DW-1:0]   slot_rdata;
  logic [1:0]      dbg_state;

  logic [AW-1:0]   addr_tab[N];
  logic [DW-1:0]   wdata_tab[N];
  logic            wr_tab[N];
  logic [DW-1:0]   exp_resp;
  int              n_cmp;
  int              n_err;

  mmio_rr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
    .resp_data(resp_data), .grant_id(grant_id), .busy(busy),
    .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
    .slot_addr(slot_addr), .slot_wdata(slot_wdata),
    .slot_rdata(slot_rdata), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_tab[i]   = wr;
    addr_tab[i] = a;
    wdata_tab[i] = d;
    req_wr[i]   = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Full transaction from IDLE: grant g expected, slot returns sv on a read.
  task automatic do_txn(input string tag, input int g, input logic [N-1:0] req_v, input logic [DW-1:0] sv);
    logic [N-1:0] exp_ack;
    req        = req_v;
    slot_rdata = sv;
    step();
    check({tag, ".grant"}, 32'(grant_id), 32'(g));
    check({tag, ".cs"}, 32'(slot_cs), 32'd1);
    check({tag, ".rd"}, 32'(slot_rd), 32'(!wr_tab[g]));
    check({tag, ".wr"}, 32'(slot_wr), 32'(wr_tab[g]));
    check({tag, ".addr"}, 32'(slot_addr), 32'(addr_tab[g]));
    if (wr_tab[g]) check({tag, ".wdata"}, slot_wdata, wdata_tab[g]);
    check({tag, ".ack_issue"}, 32'(ack), 32'd0);
    if (!wr_tab[g]) exp_resp = sv;
    step();
    exp_ack = '0;
    exp_ack[g] = 1'b1;
    check({tag, ".ack"}, 32'(ack), 32'(exp_ack));
    check({tag, ".resp"}, resp_data, exp_resp);
    check({tag, ".cs_resp"}, 32'(slot_cs), 32'd0);
    check({tag, ".busy_resp"}, 32'(busy), 32'd1);
    req = '0;
    step();
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    check({tag, ".ack_idle"}, 32'(ack), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_resp = '0;
    reset_n = 1'b0;
    req = '0;
    req_wr = '0;
    req_addr = '0;
    req_wdata = '0;
    slot_rdata = '0;
    for (int i = 0; i < N; i++) set_req(i, (i % 2) == 1, AW'(i * 5 + 2), 32'h1000_0000 + i);

    step();
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.cs", 32'(slot_cs), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.grant", 32'(grant_id), 32'd0);
    check("rst.addr", 32'(slot_addr), 32'd0);
    check("rst.wdata", slot_wdata, 32'd0);
    check("rst.resp", resp_data, 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Full contention from pointer 0: 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) do_txn("cont", k % 4, 4'b1111, 32'hC0DE_0000 + k);

    // Single read on requester 2 (pointer now 0)
    set_req(2, 1'b0, 5'h03, 32'h0);
    do_txn("rd", 2, 4'b0100, 32'hDEAD_BEEF);

    // Single write on requester 1 (pointer 3 -> search 3,0,1); resp_data must hold DEAD_BEEF
    set_req(1, 1'b1, 5'h1F, 32'h0000_00A5);
    do_txn("wr", 1, 4'b0010, 32'h1234_5678);

    // Wrap and skip: grant 2 leaves pointer 3, then 0011 -> 0 then 1, pointer ends 2
    do_txn("ws.pre", 2, 4'b0100, 32'h5555_0002);
    do_txn("ws.g0", 0, 4'b0011, 32'h5555_0000);
    do_txn("ws.g1", 1, 4'b0010, 32'h5555_0001);
    do_txn("ws.ptr", 2, 4'b0101, 32'h5555_0003);

    // Withdraw: req[0] pulses only during ISSUE of requester 3's transaction
    req = 4'b1000;
    step();
    check("wd.grant", 32'(grant_id), 32'd3);
    check("wd.cs", 32'(slot_cs), 32'd1);
    req = 4'b1001;
    step();
    check("wd.ack", 32'(ack), 32'b1000);
    req = 4'b0000;
    step();
    check("wd.cs_idle", 32'(slot_cs), 32'd0);
    check("wd.busy_idle", 32'(busy), 32'd0);
    step();
    check("wd.cs_idle2", 32'(slot_cs), 32'd0);
    check("wd.grant_hold", 32'(grant_id), 32'd3);
    do_txn("wd.ptr", 0, 4'b1111, 32'h6666_0000);

    // Reset during ISSUE: strobe drops at once and no ack follows
    req = 4'b1000;
    step();
    check("rmo.cs", 32'(slot_cs), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rmo.cs_async", 32'(slot_cs), 32'd0);
    check("rmo.busy_async", 32'(busy), 32'd0);
    check("rmo.grant_async", 32'(grant_id), 32'd0);
    check("rmo.addr_async", 32'(slot_addr), 32'd0);
    check("rmo.resp_async", resp_data, 32'd0);
    exp_resp = '0;
    req = '0;
    step();
    check("rmo.ack_held", 32'(ack), 32'd0);
    reset_n = 1'b1;
    step();
    check("rmo.ack_after", 32'(ack), 32'd0);
    check("rmo.busy_after", 32'(busy), 32'd0);
    do_txn("rmo.g3", 3, 4'b1000, 32'h7777_0003);
    do_txn("rmo.wrap", 0, 4'b1001, 32'h7777_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_rr_arbiter.md
Name: mmio_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one MMIO core slot between N_REQ independent requesters (e.g. CPU-side bridge, DMA walker, debug port).
- Accepts one single-beat read or write per grant and issues it to the slot as a one-cycle chip-select strobe.
- Returns read data with a per-requester acknowledge.
- Sits between the requesters and a single MMIO slot's cs/rd/wr/addr/data pins.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 5, slot register address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester transaction request, held until ack
req_wr  in  N_REQ  per-requester direction: 1 = write, 0 = read
req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  flattened write data, same packing
ack  out  N_REQ  one-cycle completion pulse to the granted requester
resp_data  out  DATA_W  read data; valid in the ack cycle
grant_id  out  $clog2(N_REQ)  index of current or last granted requester
busy  out  1  high in ISSUE and RESP
slot_cs  out  1  slot chip select, one-cycle strobe
slot_rd  out  1  read strobe, qualified by slot_cs
slot_wr  out  1  write strobe, qualified by slot_cs
slot_addr  out  ADDR_W  slot register address
slot_wdata  out  DATA_W  slot write data
slot_rdata  in  DATA_W  slot read data, combinationally valid while slot_cs=1 and slot_rd=1

Behaviour:
- Reset (reset_n=0, async):
  - State IDLE; priority pointer 0.
  - ack, slot_cs, slot_rd, slot_wr, busy = 0.
  - slot_addr, slot_wdata, resp_data, grant_id = 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from req to any output.
- State machine:
  - IDLE: if any req bit is set, pick the winner by round-robin starting at the pointer index, searching upward with wrap (pointer, pointer+1, ..., N_REQ-1, 0, ...).
    - Register grant_id = winner, and capture that requester's addr, wdata and wr into the slot output registers.
    - Set pointer = (winner+1) mod N_REQ; go to ISSUE.
    - If no req bit is set, stay in IDLE; pointer unchanged.
  - ISSUE (exactly 1 cycle): slot_cs=1, with slot_wr=captured wr and slot_rd=~captured wr.
    - On a read, capture slot_rdata into resp_data at the end of this cycle. On a write, resp_data holds its previous value.
    - Go to RESP.
  - RESP (exactly 1 cycle): ack[grant_id]=1, all other ack bits 0; slot_cs=0. Go to IDLE.
- Latency: req sampled in IDLE at cycle t -> slot_cs at t+1 -> ack at t+2. Peak throughput is one transaction per 3 cycles.
- Handshake:
  - A requester holds req, req_wr, req_addr and req_wdata stable from assertion until it sees ack.
  - It must drop req on the edge after ack, unless it intends a new transaction.
  - A req still high in IDLE is treated as a new transaction.
  - Requester inputs are sampled only in IDLE. Changes during ISSUE/RESP have no effect.
- Fairness: a continuously requesting requester waits at most N_REQ-1 other grants.
- Simultaneous requests are resolved only by the pointer. There is no fixed priority.
- req deasserted while not granted: the request is withdrawn with no side effect. A requester may not withdraw after being sampled in IDLE.
- Reset mid-operation (in ISSUE or RESP): transaction abandoned; slot_cs and ack drop immediately; no ack is ever issued for it.
- Width: grant_id width is $clog2(N_REQ). Pointer wraps from N_REQ-1 to 0.

Test Plan:
- Single read: N_REQ=4, req=4'b0100, req_wr[2]=0, addr2=5'h03, slot returns 32'hDEAD_BEEF -> slot_cs/slot_rd high at t+1 with slot_addr=3; ack=4'b0100 and resp_data=DEAD_BEEF at t+2; grant_id=2.
- Single write: req[1], addr=5'h1F, wdata=32'h0000_00A5 -> one-cycle slot_cs with slot_wr=1, slot_rd=0, slot_wdata=A5; ack[1] at t+2; resp_data unchanged.
- Full contention: req=4'b1111 held, each requester dropping and re-raising one cycle after its own ack -> grant order 0,1,2,3,0,...; exactly one ack bit per 3 cycles.
- Wrap and skip: pointer=3 after grant to 2, then req=4'b0011 -> grant 0 first, then 1; pointer ends at 2.
- Reset mid-operation: assert reset_n=0 in the ISSUE cycle -> slot_cs=0 asynchronously, no ack; after release, state IDLE, pointer 0, new req[3] granted normally.
- Idle and withdraw: req pulses for one cycle while another transaction is in ISSUE -> no grant; pointer unchanged; slot_cs stays 0 afterwards.
